// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - shared SHA-2 round constants and helpers
//
// Purpose: rotation amounts for Sigma0/Sigma1 at both word widths, the
// working-variable pack/unpack index helper, and the legal WORD_W check.
// Ports: none (package).

package sha2_pkg;

   localparam int SHA256_W   = 32;
   localparam int SHA512_W   = 64;
   localparam int NUM_VARS   = 8;
   localparam int COUNT_W    = 16;

   localparam int SEL_SIGMA0 = 0;
   localparam int SEL_SIGMA1 = 1;

   // Working variables; A is packed into the most significant word.
   typedef enum int {
      VAR_A = 0,
      VAR_B = 1,
      VAR_C = 2,
      VAR_D = 3,
      VAR_E = 4,
      VAR_F = 5,
      VAR_G = 6,
      VAR_H = 7
   } sha2_var_e;

   function automatic bit word_w_legal(input int word_w);
      return (word_w == SHA256_W) || (word_w == SHA512_W);
   endfunction

   // LSB position of a working variable inside the packed {a..h} vector.
   function automatic int var_lsb(input int word_w, input int var_idx);
      return (NUM_VARS - 1 - var_idx) * word_w;
   endfunction

   // Rotation amount idx (0..2) of Sigma0 (sel=0) or Sigma1 (sel=1).
   function automatic int sigma_rot(input int word_w, input int sel, input int idx);
      int r;
      r = 1;
      if (word_w == SHA256_W) begin
         if (sel == SEL_SIGMA0) r = (idx == 0) ? 2  : (idx == 1) ? 13 : 22;
         else                   r = (idx == 0) ? 6  : (idx == 1) ? 11 : 25;
      end else begin
         if (sel == SEL_SIGMA0) r = (idx == 0) ? 28 : (idx == 1) ? 34 : 39;
         else                   r = (idx == 0) ? 14 : (idx == 1) ? 18 : 41;
      end
      return r;
   endfunction

endpackage

// File: rtl/sha2_sigma.sv
// rtl/sha2_sigma.sv - combinational SHA-2 big Sigma0/Sigma1
//
// Purpose: y = ROTR(x,r0) ^ ROTR(x,r1) ^ ROTR(x,r2), rotations picked from
// sha2_pkg by WORD_W and SEL (0 = Sigma0, 1 = Sigma1).
// Ports:
//   i_x  in   WORD_W  operand word
//   o_y  out  WORD_W  Sigma result

module sha2_sigma
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int SEL    = 0
) (
   input  logic [WORD_W-1:0] i_x,
   output logic [WORD_W-1:0] o_y
);

   localparam int R0 = sigma_rot(WORD_W, SEL, 0);
   localparam int R1 = sigma_rot(WORD_W, SEL, 1);
   localparam int R2 = sigma_rot(WORD_W, SEL, 2);

   logic [WORD_W-1:0] w_r0;
   logic [WORD_W-1:0] w_r1;
   logic [WORD_W-1:0] w_r2;

   // Rotations are pure rewiring: low bits wrap around to the top.
   assign w_r0 = {i_x[R0-1:0], i_x[WORD_W-1:R0]};
   assign w_r1 = {i_x[R1-1:0], i_x[WORD_W-1:R1]};
   assign w_r2 = {i_x[R2-1:0], i_x[WORD_W-1:R2]};

   assign o_y = w_r0 ^ w_r1 ^ w_r2;

endmodule

// File: rtl/sha2_round_pipe.sv
// rtl/sha2_round_pipe.sv - two-stage SHA-2 compression round with valid/ready
//
// Purpose: one SHA-256/512 round per cycle. Stage 1 registers the Sigma,
// Ch, Maj terms, h+K+W, a..g and the tag; stage 2 registers the final sums.
// Ports:
//   clk          in   1         rising-edge clock
//   rst          in   1         synchronous active-high reset
//   in_valid     in   1         round operands present
//   in_ready     out  1         operands accepted this cycle
//   in_state     in   8*WORD_W  {a,b,c,d,e,f,g,h}, a in MSBs
//   in_k         in   WORD_W    round constant
//   in_w         in   WORD_W    schedule word
//   in_tag       in   TAG_W     opaque sideband tag
//   out_valid    out  1         result present
//   out_ready    in   1         downstream accepts result
//   out_state    out  8*WORD_W  next working variables
//   out_t1       out  WORD_W    T1 of the round
//   out_tag      out  TAG_W     tag travelling with the result
//   round_count  out  16        output handshakes, wrapping

module sha2_round_pipe
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int TAG_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*WORD_W-1:0]   in_state,
   input  logic [WORD_W-1:0]     in_k,
   input  logic [WORD_W-1:0]     in_w,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*WORD_W-1:0]   out_state,
   output logic [WORD_W-1:0]     out_t1,
   output logic [TAG_W-1:0]      out_tag,
   output logic [COUNT_W-1:0]    round_count
);

   generate
      if (!word_w_legal(WORD_W)) begin : g_illegal_word_w
         $error("sha2_round_pipe: WORD_W must be 32 or 64");
      end
   endgenerate

   localparam int VARS_W = 7 * WORD_W;

   // ---------------- input unpack and stage-1 combinational terms
   logic [WORD_W-1:0] w_a, w_b, w_c, w_e, w_f, w_g, w_h;
   logic [WORD_W-1:0] w_sig0, w_sig1, w_ch, w_maj, w_hkw;

   assign w_a = in_state[var_lsb(WORD_W, VAR_A) +: WORD_W];
   assign w_b = in_state[var_lsb(WORD_W, VAR_B) +: WORD_W];
   assign w_c = in_state[var_lsb(WORD_W, VAR_C) +: WORD_W];
   assign w_e = in_state[var_lsb(WORD_W, VAR_E) +: WORD_W];
   assign w_f = in_state[var_lsb(WORD_W, VAR_F) +: WORD_W];
   assign w_g = in_state[var_lsb(WORD_W, VAR_G) +: WORD_W];
   assign w_h = in_state[var_lsb(WORD_W, VAR_H) +: WORD_W];

   sha2_sigma #(.WORD_W(WORD_W), .SEL(SEL_SIGMA0)) u_sigma0 (
      .i_x (w_a),
      .o_y (w_sig0)
   );

   sha2_sigma #(.WORD_W(WORD_W), .SEL(SEL_SIGMA1)) u_sigma1 (
      .i_x (w_e),
      .o_y (w_sig1)
   );

   assign w_ch  = (w_e & w_f) ^ (~w_e & w_g);
   assign w_maj = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
   assign w_hkw = w_h + in_k + in_w;

   // ---------------- pipeline registers
   logic                r1_valid;
   logic [WORD_W-1:0]   r1_sig0, r1_sig1, r1_ch, r1_maj, r1_hkw;
   logic [VARS_W-1:0]   r1_vars;     // a..g, h is already folded into r1_hkw
   logic [TAG_W-1:0]    r1_tag;

   logic                r2_valid;
   logic [8*WORD_W-1:0] r2_state;
   logic [WORD_W-1:0]   r2_t1;
   logic [TAG_W-1:0]    r2_tag;

   logic [COUNT_W-1:0]  r_round_count;

   // A stage may load when the stage after it is empty or draining.
   logic w_s2_adv;
   assign w_s2_adv = !r2_valid || out_ready;
   assign in_ready = !r1_valid || !r2_valid || out_ready;

   // ---------------- stage-2 combinational sums
   logic [WORD_W-1:0]   w1_a, w1_b, w1_c, w1_d, w1_e, w1_f, w1_g;
   logic [WORD_W-1:0]   w_t1, w_t2;
   logic [8*WORD_W-1:0] w_next_state;

   // r1_vars drops h, so every index is shifted down by one word.
   assign w1_a = r1_vars[var_lsb(WORD_W, VAR_A) - WORD_W +: WORD_W];
   assign w1_b = r1_vars[var_lsb(WORD_W, VAR_B) - WORD_W +: WORD_W];
   assign w1_c = r1_vars[var_lsb(WORD_W, VAR_C) - WORD_W +: WORD_W];
   assign w1_d = r1_vars[var_lsb(WORD_W, VAR_D) - WORD_W +: WORD_W];
   assign w1_e = r1_vars[var_lsb(WORD_W, VAR_E) - WORD_W +: WORD_W];
   assign w1_f = r1_vars[var_lsb(WORD_W, VAR_F) - WORD_W +: WORD_W];
   assign w1_g = r1_vars[var_lsb(WORD_W, VAR_G) - WORD_W +: WORD_W];

   assign w_t1 = r1_hkw + r1_sig1 + r1_ch;
   assign w_t2 = r1_sig0 + r1_maj;
   assign w_next_state = {w_t1 + w_t2, w1_a, w1_b, w1_c,
                          w_t1 + w1_d, w1_e, w1_f, w1_g};

   // ---------------- control state
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid      <= 1'b0;
         r2_valid      <= 1'b0;
         r_round_count <= '0;
      end else begin
         if (in_ready) r1_valid <= in_valid;
         if (w_s2_adv) r2_valid <= r1_valid;
         if (r2_valid && out_ready) r_round_count <= r_round_count + 1'b1;
      end
   end

   // ---------------- data registers (meaningless while their valid is low)
   always_ff @(posedge clk) begin
      if (in_ready && in_valid) begin
         r1_sig0 <= w_sig0;
         r1_sig1 <= w_sig1;
         r1_ch   <= w_ch;
         r1_maj  <= w_maj;
         r1_hkw  <= w_hkw;
         r1_vars <= in_state[8*WORD_W-1:WORD_W];
         r1_tag  <= in_tag;
      end
      if (w_s2_adv && r1_valid) begin
         r2_state <= w_next_state;
         r2_t1    <= w_t1;
         r2_tag   <= r1_tag;
      end
   end

   assign out_valid   = r2_valid;
   assign out_state   = r2_state;
   assign out_t1      = r2_t1;
   assign out_tag     = r2_tag;
   assign round_count = r_round_count;

endmodule

// File: doc/sha2_round_pipe.md
SHA2_ROUND_PIPE -- requirements
Module: sha2_round_pipe

Interface
REQ-001 SHALL have parameter WORD_W, default 32, SHA-2 word width; legal values 32 (SHA-256) and 64 (SHA-512), any other value is an elaboration error.
REQ-002 SHALL have parameter TAG_W, default 8, width of the sideband tag carried alongside each round.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input round operands present.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port in_state  input  8*WORD_W  working variables {a,b,c,d,e,f,g,h}, a in MSBs.
REQ-008 SHALL have port in_k  input  WORD_W  round constant K[t].
REQ-009 SHALL have port in_w  input  WORD_W  schedule word W[t].
REQ-010 SHALL have port in_tag  input  TAG_W  opaque tag.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_state  output  8*WORD_W  next working variables, same packing as in_state.
REQ-014 SHALL have port out_t1  output  WORD_W  T1 of the round.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the input that produced this result.
REQ-016 SHALL have port round_count  output  16  number of results accepted downstream.

Function
REQ-017 SHALL accept an input on any cycle where in_valid && in_ready, and deliver a result on any cycle where out_valid && out_ready.
REQ-018 SHALL be a 2-stage pipeline. Stage 1 registers:
- Sigma1(e), Ch(e,f,g) = (e&f)^(~e&g), and h+K+W;
- Sigma0(a), Maj(a,b,c) = (a&b)^(a&c)^(b&c);
- a..g and the tag.
Stage 2 registers the final sums.
REQ-019 SHALL compute T1 = h+Sigma1(e)+Ch(e,f,g)+K+W and T2 = Sigma0(a)+Maj(a,b,c), all additions modulo 2^WORD_W with carries discarded.
REQ-020 SHALL produce out_state = {T1+T2, a, b, c, T1+d, e, f, g}.
REQ-021 SHALL use Sigma0 = ROTR2^ROTR13^ROTR22 and Sigma1 = ROTR6^ROTR11^ROTR25 for WORD_W=32.
REQ-022 SHALL use Sigma0 = ROTR28^ROTR34^ROTR39 and Sigma1 = ROTR14^ROTR18^ROTR41 for WORD_W=64.
REQ-023 SHALL have a latency of exactly 2 cycles from acceptance to out_valid when out_ready is held high, and SHALL sustain throughput of 1 round per cycle.
REQ-024 SHALL drive in_ready = !stage1_valid || !stage2_valid || out_ready, i.e. a stage advances when the stage after it is empty or draining.
REQ-025 SHALL hold out_state, out_t1 and out_tag stable while out_valid && !out_ready, and SHALL not drop or duplicate a result under any valid/ready pattern.
REQ-026 SHALL keep out_valid asserted until the handshake completes once it is high.
REQ-027 SHALL fully occupy both stages (one result held at the output, one in stage 1) when the pipeline is full with out_ready low, then deassert in_ready.
REQ-028 SHALL, on simultaneous input accept and output drain with both stages full, shift both stages in the same cycle with no bubble.
REQ-029 SHALL increment round_count on each output handshake, wrapping from 0xFFFF to 0x0000.
REQ-030 SHALL leave data registers holding don't-care values while their valid bit is low, and outputs are only meaningful with out_valid.

Reset
REQ-031 SHALL, with rst high at a rising edge, clear both stage valid bits, out_valid and round_count to 0, and drive in_ready to 1 on the following cycle.
REQ-032 SHALL discard any in-flight rounds on a mid-operation reset, with no result emitted for them.
REQ-033 SHALL ignore in_valid on the reset cycle.

Structure
REQ-034 SHALL place the rotation constants for both widths, the state pack/unpack index helpers and the legal WORD_W check in a shared package sha2_pkg.
REQ-035 SHALL implement Sigma0/Sigma1 in one combinational sub-module sha2_sigma (parameters WORD_W, SEL), instantiated twice.

Verification
REQ-036 SHALL pass SHA-256 round 0 of "abc":
- in_state = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, K=428a2f98, W=61626380;
- required: out_state = 5d6aebcd 6a09e667 bb67ae85 3c6ef372 fa2a4622 510e527f 9b05688c 1f83d9ab and out_t1 = 54da50e8, exactly 2 cycles after accept.
REQ-037 SHALL pass SHA-512 round 0 of "abc" (WORD_W=64):
- SHA-512 IVs, K=428a2f98d728ae22, W=6162638000000000;
- required: a' = f6afceb8bcfcddf5, e' = 58cb02347ab51f91.
REQ-038 SHALL pass backpressure: 4 back-to-back inputs (tags 1..4) with out_ready low for 5 cycles.
- in_ready drops after 2 accepts;
- after release, tags emerge 1,2,3,4 in order with no loss.
REQ-039 SHALL pass a random valid/ready test: 1000 rounds with random stalls on both sides; every result matches a reference model, and round_count = 1000 mod 65536.
REQ-040 SHALL pass mid-flight reset: rst pulsed with 2 rounds in flight.
- required: out_valid = 0 the next cycle, round_count = 0, and no stale tag appears later.
REQ-041 SHALL pass wrap-around: preload 0xFFFF handshakes, one more -> round_count = 0x0000.
